// File: rtl/decode_pkg.sv
// Shared types and constants for the RISC-V instruction-decode stage.
// Class codes, opcode values, SYS flag positions and the decoded-field struct.
package decode_pkg;

   typedef enum logic [3:0] {
      CLS_LOAD      = 4'd0,
      CLS_STORE     = 4'd1,
      CLS_BRANCH    = 4'd2,
      CLS_JAL       = 4'd3,
      CLS_JALR      = 4'd4,
      CLS_LUI       = 4'd5,
      CLS_AUIPC     = 4'd6,
      CLS_OP_IMM    = 4'd7,
      CLS_OP        = 4'd8,
      CLS_OP_IMM_32 = 4'd9,
      CLS_OP_32     = 4'd10,
      CLS_MISC_MEM  = 4'd11,
      CLS_SYSTEM    = 4'd12,
      CLS_ILLEGAL   = 4'd15
   } cls_e;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   localparam int unsigned SYS_MRET   = 0;
   localparam int unsigned SYS_SRET   = 1;
   localparam int unsigned SYS_ECALL  = 2;
   localparam int unsigned SYS_EBREAK = 3;
   localparam int unsigned SYS_WFI    = 4;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [11:0] csr;
      cls_e        cls;
      logic [4:0]  sys;
      logic        illegal;
   } fields_t;

   function automatic logic [4:0] sys_bit(input int unsigned pos);
      return 5'b00001 << pos;
   endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational RISC-V field extraction: register/function fields, class,
// SYSTEM flags, legality and the class-selected sign-extended immediate.
module inst_field_decode
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     instr,
   output fields_t         fields,
   output logic [XLEN-1:0] imm
);

   typedef logic [XLEN-1:0] xword_t;

   logic [6:0] opcode;
   logic       bad;
   xword_t     imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = instr[6:0];
   assign imm_i  = xword_t'($signed(instr[31:20]));
   assign imm_s  = xword_t'($signed({instr[31:25], instr[11:7]}));
   assign imm_b  = xword_t'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
   assign imm_u  = xword_t'($signed({instr[31:12], 12'b0}));
   assign imm_j  = xword_t'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

   always_comb begin
      fields         = '0;
      fields.rs1     = instr[19:15];
      fields.rs2     = instr[24:20];
      fields.rd      = instr[11:7];
      fields.funct3  = instr[14:12];
      fields.funct7  = instr[31:25];
      fields.csr     = instr[31:20];
      fields.cls     = CLS_ILLEGAL;
      imm            = '0;
      bad            = 1'b0;
      case (opcode)
         OPC_LOAD:     begin fields.cls = CLS_LOAD;     imm = imm_i; end
         OPC_STORE:    begin fields.cls = CLS_STORE;    imm = imm_s; end
         OPC_BRANCH:   begin fields.cls = CLS_BRANCH;   imm = imm_b; end
         OPC_JAL:      begin fields.cls = CLS_JAL;      imm = imm_j; end
         OPC_JALR:     begin fields.cls = CLS_JALR;     imm = imm_i; end
         OPC_LUI:      begin fields.cls = CLS_LUI;      imm = imm_u; end
         OPC_AUIPC:    begin fields.cls = CLS_AUIPC;    imm = imm_u; end
         OPC_OP_IMM:   begin fields.cls = CLS_OP_IMM;   imm = imm_i; end
         OPC_OP:             fields.cls = CLS_OP;
         OPC_MISC_MEM: begin fields.cls = CLS_MISC_MEM; imm = imm_i; end
         OPC_OP_IMM_32: begin
            if (XLEN == 32) bad = 1'b1;
            else begin fields.cls = CLS_OP_IMM_32; imm = imm_i; end
         end
         OPC_OP_32: begin
            if (XLEN == 32) bad = 1'b1;
            else fields.cls = CLS_OP_32;
         end
         OPC_SYSTEM: begin
            fields.cls = CLS_SYSTEM;
            imm        = imm_i;
            // CSR ops (funct3 != 0) are legal with no flag; funct3 0 must hit a known privileged op
            if (instr[14:12] == 3'b000) begin
               if (instr[11:7] != 5'd0 || instr[19:15] != 5'd0)          bad = 1'b1;
               else if (instr[31:25] == 7'b0011000 && instr[24:20] == 5'd2) fields.sys = sys_bit(SYS_MRET);
               else if (instr[31:25] == 7'b0001000 && instr[24:20] == 5'd2) fields.sys = sys_bit(SYS_SRET);
               else if (instr[31:20] == 12'h000)                         fields.sys = sys_bit(SYS_ECALL);
               else if (instr[31:20] == 12'h001)                         fields.sys = sys_bit(SYS_EBREAK);
               else if (instr[31:20] == 12'h105)                         fields.sys = sys_bit(SYS_WFI);
               else                                                      bad = 1'b1;
            end
         end
         default: bad = 1'b1;
      endcase
      if (instr[1:0] != 2'b11) bad = 1'b1;
      if (bad) begin
         fields.cls     = CLS_ILLEGAL;
         fields.sys     = '0;
         fields.illegal = 1'b1;
         imm            = '0;
      end
   end

endmodule

// File: rtl/inst_decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready on both sides,
// two-entry skid buffer (main + skid), flush, async active-low reset.
module inst_decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic            FLUSH,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [XLEN-1:0] IN_PC,
   input  logic [31:0]     IN_INSTR,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [XLEN-1:0] OUT_PC,
   output logic [4:0]      OUT_RS1,
   output logic [4:0]      OUT_RS2,
   output logic [4:0]      OUT_RD,
   output logic [2:0]      OUT_FUNCT3,
   output logic [6:0]      OUT_FUNCT7,
   output logic [11:0]     OUT_CSR,
   output logic [XLEN-1:0] OUT_IMM,
   output logic [3:0]      OUT_CLASS,
   output logic [4:0]      OUT_SYS,
   output logic            OUT_ILLEGAL
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      fields_t         f;
   } entry_t;

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;

   state_e          state;
   entry_t          main_q, skid_q, dec;
   fields_t         dec_fields;
   logic [XLEN-1:0] dec_imm;
   logic            in_ready_q, out_valid_q;
   logic            accept, drain;

   inst_field_decode #(.XLEN(XLEN)) u_field_decode (
      .instr  (IN_INSTR),
      .fields (dec_fields),
      .imm    (dec_imm)
   );

   assign dec    = '{pc: IN_PC, imm: dec_imm, f: dec_fields};
   assign accept = IN_VALID & in_ready_q;
   assign drain  = out_valid_q & OUT_READY;

   // Ready/valid are registered alongside state so neither depends on OUT_READY combinationally
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state         <= ST_EMPTY;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         main_q        <= '0;
         main_q.f.cls  <= CLS_ILLEGAL;
         skid_q        <= '0;
         skid_q.f.cls  <= CLS_ILLEGAL;
      end else if (FLUSH) begin
         state       <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  main_q      <= dec;
                  state       <= ST_ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ST_ONE: begin
               case ({accept, drain})
                  2'b10: begin
                     skid_q     <= dec;
                     state      <= ST_FULL;
                     in_ready_q <= 1'b0;
                  end
                  2'b01: begin
                     state       <= ST_EMPTY;
                     out_valid_q <= 1'b0;
                  end
                  2'b11:   main_q <= dec;
                  default: ;
               endcase
            end
            ST_FULL: begin
               if (drain) begin
                  main_q     <= skid_q;
                  state      <= ST_ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state       <= ST_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign IN_READY    = in_ready_q;
   assign OUT_VALID   = out_valid_q;
   assign OUT_PC      = main_q.pc;
   assign OUT_IMM     = main_q.imm;
   assign OUT_RS1     = main_q.f.rs1;
   assign OUT_RS2     = main_q.f.rs2;
   assign OUT_RD      = main_q.f.rd;
   assign OUT_FUNCT3  = main_q.f.funct3;
   assign OUT_FUNCT7  = main_q.f.funct7;
   assign OUT_CSR     = main_q.f.csr;
   assign OUT_CLASS   = main_q.f.cls;
   assign OUT_SYS     = main_q.f.sys;
   assign OUT_ILLEGAL = main_q.f.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Scoreboard bench: an RV64 and an RV32 instance share one stimulus stream;
// expected entries come from a behavioural RISC-V decode model.
module tb_inst_decode_stage;
   import decode_pkg::*;

   typedef struct {
      logic [63:0] pc, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [11:0] csr;
      logic [3:0]  cls;
      logic [4:0]  sys;
      logic        ill;
   } exp_t;

   logic        clk, rst_n, flush, in_valid, out_ready;
   logic [63:0] in_pc;
   logic [31:0] in_instr;

   logic        a_in_ready, a_out_valid, a_ill;
   logic [63:0] a_pc, a_imm;
   logic [4:0]  a_rs1, a_rs2, a_rd, a_sys;
   logic [2:0]  a_f3;
   logic [6:0]  a_f7;
   logic [11:0] a_csr;
   logic [3:0]  a_cls;

   logic        b_in_ready, b_out_valid, b_ill;
   logic [31:0] b_pc, b_imm;
   logic [4:0]  b_rs1, b_rs2, b_rd, b_sys;
   logic [2:0]  b_f3;
   logic [6:0]  b_f7;
   logic [11:0] b_csr;
   logic [3:0]  b_cls;

   int   tests = 0;
   int   fails = 0;
   int   pops  = 0;
   exp_t q64[$];
   exp_t q32[$];

   inst_decode_stage #(.XLEN(64)) u64 (
      .CLK(clk), .RSTn(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(a_in_ready),
      .IN_PC(in_pc), .IN_INSTR(in_instr), .OUT_VALID(a_out_valid), .OUT_READY(out_ready),
      .OUT_PC(a_pc), .OUT_RS1(a_rs1), .OUT_RS2(a_rs2), .OUT_RD(a_rd), .OUT_FUNCT3(a_f3),
      .OUT_FUNCT7(a_f7), .OUT_CSR(a_csr), .OUT_IMM(a_imm), .OUT_CLASS(a_cls),
      .OUT_SYS(a_sys), .OUT_ILLEGAL(a_ill));

   inst_decode_stage #(.XLEN(32)) u32 (
      .CLK(clk), .RSTn(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(b_in_ready),
      .IN_PC(in_pc[31:0]), .IN_INSTR(in_instr), .OUT_VALID(b_out_valid), .OUT_READY(out_ready),
      .OUT_PC(b_pc), .OUT_RS1(b_rs1), .OUT_RS2(b_rs2), .OUT_RD(b_rd), .OUT_FUNCT3(b_f3),
      .OUT_FUNCT7(b_f7), .OUT_CSR(b_csr), .OUT_IMM(b_imm), .OUT_CLASS(b_cls),
      .OUT_SYS(b_sys), .OUT_ILLEGAL(b_ill));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode written straight from the RISC-V encoding rules
   function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc, input int xlen);
      exp_t   e;
      longint imm = 0;
      bit     bad = 0;
      int     k   = -1;
      e.pc  = pc;  e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
      e.f3  = i[14:12]; e.f7 = i[31:25]; e.csr = i[31:20];
      e.cls = CLS_ILLEGAL;
      case (i[6:0])
         7'h03: begin e.cls = CLS_LOAD;     imm = longint'($signed(i[31:20])); end
         7'h23: begin e.cls = CLS_STORE;    imm = longint'($signed({i[31:25], i[11:7]})); end
         7'h63: begin e.cls = CLS_BRANCH;   imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
         7'h6F: begin e.cls = CLS_JAL;      imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
         7'h67: begin e.cls = CLS_JALR;     imm = longint'($signed(i[31:20])); end
         7'h37: begin e.cls = CLS_LUI;      imm = longint'($signed({i[31:12], 12'b0})); end
         7'h17: begin e.cls = CLS_AUIPC;    imm = longint'($signed({i[31:12], 12'b0})); end
         7'h13: begin e.cls = CLS_OP_IMM;   imm = longint'($signed(i[31:20])); end
         7'h33:       e.cls = CLS_OP;
         7'h0F: begin e.cls = CLS_MISC_MEM; imm = longint'($signed(i[31:20])); end
         7'h1B: begin e.cls = CLS_OP_IMM_32; imm = longint'($signed(i[31:20])); bad = (xlen == 32); end
         7'h3B: begin e.cls = CLS_OP_32;    bad = (xlen == 32); end
         7'h73: begin
            e.cls = CLS_SYSTEM;
            imm   = longint'($signed(i[31:20]));
            if (i[14:12] == 0) begin
               if (i[11:7] != 0 || i[19:15] != 0)          bad = 1;
               else if (i[31:25] == 7'h18 && i[24:20] == 2) k = 0;
               else if (i[31:25] == 7'h08 && i[24:20] == 2) k = 1;
               else if (i[31:20] == 12'h000)                k = 2;
               else if (i[31:20] == 12'h001)                k = 3;
               else if (i[31:20] == 12'h105)                k = 4;
               else                                         bad = 1;
            end
         end
         default: bad = 1;
      endcase
      e.sys = (k >= 0) ? 5'(1 << k) : 5'd0;
      e.ill = bad;
      if (bad) begin e.cls = CLS_ILLEGAL; e.sys = 0; imm = 0; end
      e.imm = imm;
      if (xlen == 32) begin e.imm = e.imm & 64'hFFFF_FFFF; e.pc = e.pc & 64'hFFFF_FFFF; end
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [6:0]  opcs[13] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
                                7'h13, 7'h33, 7'h0F, 7'h1B, 7'h3B, 7'h73};
      logic [31:0] sysl[5]  = '{32'h30200073, 32'h10200073, 32'h00000073,
                                32'h00100073, 32'h10500073};
      int unsigned r = $urandom_range(0, 9);
      if (r == 0) return sysl[$urandom_range(0, 4)];
      if (r == 1) return $urandom();
      if (r == 2) return ($urandom() & 32'hFFF0_0F80) | 32'h73;
      return ($urandom() & 32'hFFFF_FF80) | {25'b0, opcs[$urandom_range(0, 12)]};
   endfunction

   // One cycle of stimulus; the scoreboard learns of each input handshake here
   task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic ordy, input logic fl);
      @(negedge clk);
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
      #1;
      if (fl) begin
         q64.delete();
         q32.delete();
      end else if (v && a_in_ready) begin
         q64.push_back(model(ins, pc, 64));
         q32.push_back(model(ins, {32'b0, pc[31:0]}, 32));
      end
   endtask

   task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
      drive(1'b1, ins, pc, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
   endtask

   // Monitor: compares whenever an output handshake happens
   always @(negedge clk) begin
      #2;
      if (rst_n && !flush && a_out_valid && out_ready) begin
         if (q64.size() == 0 || q32.size() == 0) begin
            tests++; fails++;
            $display("FAIL phantom_output: got pc 0x%0h, expected no entry at %0t", a_pc, $time);
         end else begin
            exp_t e, f;
            e = q64.pop_front();
            f = q32.pop_front();
            pops++;
            chk("x64_pc", a_pc, e.pc);
            chk("x64_imm", a_imm, e.imm);
            chk("x64_fields", {a_rs1, a_rs2, a_rd, a_f3, a_f7, a_csr}, {e.rs1, e.rs2, e.rd, e.f3, e.f7, e.csr});
            chk("x64_class", a_cls, e.cls);
            chk("x64_sys", a_sys, e.sys);
            chk("x64_illegal", a_ill, e.ill);
            chk("x32_valid", b_out_valid, 1'b1);
            chk("x32_pc", b_pc, f.pc);
            chk("x32_imm", b_imm, f.imm);
            chk("x32_fields", {b_rs1, b_rs2, b_rd, b_f3, b_f7, b_csr}, {f.rs1, f.rs2, f.rd, f.f3, f.f7, f.csr});
            chk("x32_class", b_cls, f.cls);
            chk("x32_sys", b_sys, f.sys);
            chk("x32_illegal", b_ill, f.ill);
         end
      end
   end

   task automatic chk_reset_values(input string tag);
      chk({tag, "_out_valid"}, {a_out_valid, b_out_valid}, 2'b00);
      chk({tag, "_in_ready"}, {a_in_ready, b_in_ready}, 2'b11);
      chk({tag, "_pc_imm"}, a_pc | a_imm | {32'b0, b_pc | b_imm}, 64'h0);
      chk({tag, "_class"}, {a_cls, b_cls}, {CLS_ILLEGAL, CLS_ILLEGAL});
      chk({tag, "_sys_ill"}, {a_sys, b_sys, a_ill, b_ill}, 12'h0);
      chk({tag, "_fields"}, {a_rs1, a_rs2, a_rd, a_f3, a_f7, a_csr}, 37'h0);
   endtask

   initial begin
      logic [31:0] sys_ins[5] = '{32'h30200073, 32'h10200073, 32'h00000073, 32'h00100073, 32'h10500073};
      int          p0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_instr = '0;
      repeat (3) @(negedge clk);
      chk_reset_values("reset");
      rst_n = 1'b1;

      for (int s = 0; s < 5; s++) begin
         issue(sys_ins[s], 64'h100);
         chk("sys_valid", a_out_valid, 1'b1);
         chk("sys_flags", a_sys, 64'(5'b00001 << s));
         chk("sys_class", a_cls, CLS_SYSTEM);
         chk("sys_pc", a_pc, 64'h100);
         chk("sys_illegal", a_ill, 1'b0);
      end

      issue(32'hFFF00093, 64'h200);
      chk("addi_imm64", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_rd", a_rd, 5'd1);
      chk("addi_class", a_cls, CLS_OP_IMM);
      issue(32'hFE000EE3, 64'h204);
      chk("branch_imm64", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("branch_imm32", b_imm, 32'hFFFF_FFFC);
      issue(32'h0000001B, 64'h208);
      chk("addiw_x32_illegal", {b_ill, b_cls}, {1'b1, CLS_ILLEGAL});
      chk("addiw_x64_legal", {a_ill, a_cls}, {1'b0, CLS_OP_IMM_32});
      issue(32'h00000000, 64'h20C);
      chk("zero_illegal", {a_ill, b_ill}, 2'b11);

      // Backpressure: three offers with OUT_READY low, then release
      drive(1'b1, 32'h00100093, 64'h300, 1'b0, 1'b0);
      drive(1'b1, 32'h00200113, 64'h304, 1'b0, 1'b0);
      drive(1'b1, 32'h00300193, 64'h308, 1'b0, 1'b0);
      chk("bp_in_ready_full", a_in_ready, 1'b0);
      chk("bp_head_held", a_pc, 64'h300);
      drive(1'b1, 32'h00300193, 64'h308, 1'b1, 1'b0);
      drive(1'b1, 32'h00300193, 64'h308, 1'b1, 1'b0);
      chk("bp_third_taken", q64.size(), 64'd2);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      chk("bp_drained", q64.size(), 64'd0);

      // Flush in FULL with an offer, and in ONE with accept plus output handshake
      drive(1'b1, 32'h00400213, 64'h400, 1'b0, 1'b0);
      drive(1'b1, 32'h00500293, 64'h404, 1'b0, 1'b0);
      drive(1'b1, 32'h00600313, 64'h408, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      chk("flush_full_valid", a_out_valid, 1'b0);
      chk("flush_full_ready", a_in_ready, 1'b1);
      drive(1'b1, 32'h00700393, 64'h40C, 1'b0, 1'b0);
      drive(1'b1, 32'h00800413, 64'h410, 1'b1, 1'b1);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      chk("flush_one_valid", a_out_valid, 1'b0);
      issue(32'h00900493, 64'h414);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      chk("flush_after_empty", q64.size(), 64'd0);

      // Asynchronous reset while FULL
      drive(1'b1, 32'h00A00513, 64'h500, 1'b0, 1'b0);
      drive(1'b1, 32'h00B00593, 64'h504, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1 chk_reset_values("async_reset");
      q64.delete();
      q32.delete();
      @(negedge clk);
      rst_n = 1'b1;
      p0 = pops;
      issue(32'h00C00613, 64'h600);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      chk("post_reset_single", 64'(pops - p0), 64'd1);

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 9) < 8), gen_instr(), {$urandom(), $urandom()} & ~64'h3,
               ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
      end
      for (int n = 0; n < 20 && q64.size() != 0; n++) drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      chk("final_drain", q64.size(), 64'd0);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      chk("final_idle", a_out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Registered instruction-decode pipeline stage with a valid/ready handshake and a 2-entry skid buffer. It sits between fetch and execute. It splits a 32-bit RISC-V instruction into register indices, function fields, CSR address, a sign-extended immediate, an opcode class, one-hot system-instruction flags and an illegal flag. It generalises single-word field extraction to a parametrised XLEN, adds RV64 word-op legality and SYSTEM decode beyond MRET, and adds flush and backpressure handling.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64. Sets PC and immediate width and RV64 opcode legality.
- CLK  in  1  clock; all state on rising edge
- RSTn  in  1  asynchronous, active-low reset
- FLUSH  in  1  discard all buffered entries
- IN_VALID  in  1  fetch offers an instruction
- IN_READY  out  1  stage can accept
- IN_PC  in  XLEN  PC of offered instruction
- IN_INSTR  in  32  instruction word
- OUT_VALID  out  1  decoded entry available
- OUT_READY  in  1  execute accepts
- OUT_PC  out  XLEN  PC of entry
- OUT_RS1, OUT_RS2, OUT_RD  out  5 each  fields [19:15], [24:20], [11:7]
- OUT_FUNCT3  out  3  field [14:12]
- OUT_FUNCT7  out  7  field [31:25]
- OUT_CSR  out  12  field [31:20]
- OUT_IMM  out  XLEN  sign-extended immediate, format chosen by class
- OUT_CLASS  out  4  opcode class code
- OUT_SYS  out  5  one-hot flags, bit order {wfi, ebreak, ecall, sret, mret}
- OUT_ILLEGAL  out  1  unrecognised encoding

## Operation
- Decode is combinational on IN_INSTR. The result is captured with IN_PC on input handshake (IN_VALID & IN_READY).
- Classes: LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP_IMM, OP, OP_IMM_32, OP_32, MISC_MEM, SYSTEM, ILLEGAL.
- Immediate formats:
  - I: inst[31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
- All immediates are sign-extended from inst[31] to XLEN. The immediate is 0 for OP, OP_32 and ILLEGAL.
- SYSTEM flags require opcode 1110011, funct3 000, rd 0 and rs1 0, then:
  - mret: funct7 0011000, rs2 00010
  - sret: funct7 0001000, rs2 00010
  - ecall: csr 0x000
  - ebreak: csr 0x001
  - wfi: csr 0x105
  - At most one flag is set. A SYSTEM/funct3 000 encoding matching none of these is illegal.
- OUT_ILLEGAL is set when any of these hold:
  - inst[1:0] != 11
  - the opcode is unrecognised
  - the opcode is OP_IMM_32 or OP_32 and XLEN=32
- On an illegal entry, OUT_CLASS=ILLEGAL and OUT_SYS=0.
- Buffer states: EMPTY, ONE (main valid), FULL (main and skid valid).
  - EMPTY + accept → ONE
  - ONE + accept and no output handshake → FULL (new entry goes to skid)
  - ONE + output handshake, no accept → EMPTY
  - ONE + both → ONE (main reloaded)
  - FULL + output handshake → ONE (skid moves to main). No accept is possible in FULL.
- Ordering is strictly FIFO. Entries are never duplicated or dropped except by FLUSH.

## Timing
- Latency: input handshake in cycle N → OUT_VALID high in cycle N+1.
- IN_READY = (state != FULL). It is a registered decode of state with no combinational path from OUT_READY.
- OUT_VALID = (state != EMPTY). OUT_* hold stable while OUT_VALID & !OUT_READY.
- FLUSH → state EMPTY next cycle. Any input handshake in the same cycle is dropped, and FLUSH wins over a simultaneous output handshake.
- Reset values: state EMPTY, OUT_VALID 0, IN_READY 1, all data outputs 0, OUT_CLASS=ILLEGAL code, OUT_SYS 0, OUT_ILLEGAL 0.
- RSTn asserted mid-operation clears state immediately (asynchronously).
- Full throughput: one instruction per cycle with OUT_READY held high.

## Structure
- Shared package decode_pkg:
  - class enum (4-bit)
  - opcode constants
  - SYS flag bit positions
  - decoded-entry struct (pc, fields, imm, class, sys, illegal), parametrised by XLEN through a typedef in the using module
- One combinational sub-module inst_field_decode (instr → decoded-entry struct, XLEN parameter). The stage instantiates it once and holds two struct registers plus a 2-bit state.

## Test plan
- Reset, then 0x30200073 (mret) at PC 0x100 → next cycle OUT_VALID=1, OUT_SYS=00001, OUT_CLASS=SYSTEM, OUT_PC=0x100, OUT_ILLEGAL=0. Repeat for 0x10200073 / 0x00000073 / 0x00100073 / 0x10500073 → sret / ecall / ebreak / wfi bits.
- 0xFFF00093 (addi x1,x0,-1), XLEN=64 → OUT_IMM=0xFFFF_FFFF_FFFF_FFFF, OUT_RD=1, OUT_CLASS=OP_IMM. Branch 0xFE000EE3 → OUT_IMM=-4.
- 0x0000001B (addiw) → illegal with XLEN=32, OP_IMM_32 with XLEN=64. 0x00000000 → OUT_ILLEGAL=1 for both.
- OUT_READY=0 while 3 instructions are offered back-to-back → 2 accepted, IN_READY=0 from the cycle after the 2nd. OUT_READY=1 → both emerge in order, then the 3rd is accepted.
- FLUSH in FULL state with a simultaneous IN_VALID → next cycle OUT_VALID=0, IN_READY=1, and no flushed or dropped entry ever appears at the output.
- RSTn pulsed low mid-stream in FULL state → outputs take reset values immediately, and the first post-reset instruction emerges alone.
